// File: rtl/dsp_stream_pkg.sv
// Shared types and sizing helpers for the IQ sample-stream blocks.
package dsp_stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // Words per burst: one I and one Q per channel.
    function automatic int unsigned burst_len(input int unsigned n_ch);
        return 2 * n_ch;
    endfunction

    function automatic int unsigned idx_width(input int unsigned n_ch);
        return (2 * n_ch > 2) ? $clog2(2 * n_ch) : 1;
    endfunction

    // Bit offset of channel k inside a packed bus of dw-wide words.
    function automatic int unsigned ch_lsb(input int unsigned k, input int unsigned dw);
        return k * dw;
    endfunction

endpackage

// File: rtl/iq_frame_slot.sv
// One captured I/Q frame with a valid flag; load takes priority over clear.
module iq_frame_slot #(
    parameter int unsigned FW = 124
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          clear,
    input  logic [FW-1:0] load_i,
    input  logic [FW-1:0] load_q,
    output logic [FW-1:0] frame_i,
    output logic [FW-1:0] frame_q,
    output logic          valid
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_i <= '0;
            frame_q <= '0;
            valid   <= 1'b0;
        end else if (load) begin
            frame_i <= load_i;
            frame_q <= load_q;
            valid   <= 1'b1;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/iq_stream_serializer.sv
// Serializes N_CH parallel I/Q pairs into bursts I0,Q0,I1,Q1,... on one bus,
// with a one-deep pending queue and an optional idle gap between bursts.
module iq_stream_serializer
    import dsp_stream_pkg::*;
#(
    parameter int unsigned DW   = 31,
    parameter int unsigned N_CH = 4,
    parameter int unsigned GAP  = 0
) (
    input  logic                 sample_clk,
    input  logic                 sample_rst_n,
    input  logic                 strobe_in,
    input  logic [N_CH*DW-1:0]   i_in,
    input  logic [N_CH*DW-1:0]   q_in,
    input  logic                 ovf_clr,
    output logic [DW-1:0]        stream_out,
    output logic                 strobe_out,
    output logic                 frame_start,
    output logic                 busy,
    output logic [7:0]           ovf_cnt
);

    localparam int unsigned FW       = N_CH * DW;
    localparam int unsigned BURST    = burst_len(N_CH);
    localparam int unsigned IW       = idx_width(N_CH);
    localparam logic [IW-1:0] LAST   = IW'(BURST - 1);
    localparam logic [3:0] GAP_LAST  = 4'((GAP > 0) ? GAP - 1 : 0);

    state_t          state;
    logic [IW-1:0]   widx;
    logic [3:0]      gcnt;

    logic [FW-1:0]   shad_i, shad_q, pend_i, pend_q, src_i, src_q;
    logic            shad_valid, pend_valid;
    logic            last_word, last_gap, consume, start, from_pend;
    logic            pend_load, pend_clear, shad_clear, drop;
    logic            stay_active, nxt_pend_valid;
    logic [IW-1:0]   nidx;
    logic [DW-1:0]   next_word;

    iq_frame_slot #(.FW(FW)) u_shadow (
        .clk     (sample_clk),
        .rst_n   (sample_rst_n),
        .load    (start),
        .clear   (shad_clear),
        .load_i  (src_i),
        .load_q  (src_q),
        .frame_i (shad_i),
        .frame_q (shad_q),
        .valid   (shad_valid)
    );

    iq_frame_slot #(.FW(FW)) u_pending (
        .clk     (sample_clk),
        .rst_n   (sample_rst_n),
        .load    (pend_load),
        .clear   (pend_clear),
        .load_i  (i_in),
        .load_q  (q_in),
        .frame_i (pend_i),
        .frame_q (pend_q),
        .valid   (pend_valid)
    );

    // Burst sequencing decisions; consume marks the cycle a queued frame may start.
    always_comb begin
        last_word      = 1'b0;
        last_gap       = 1'b0;
        consume        = 1'b0;
        from_pend      = 1'b0;
        start          = 1'b0;
        pend_load      = 1'b0;
        pend_clear     = 1'b0;
        shad_clear     = 1'b0;
        drop           = 1'b0;
        stay_active    = 1'b0;
        nxt_pend_valid = 1'b0;
        src_i          = i_in;
        src_q          = q_in;
        nidx           = widx + IW'(1);

        last_word = (state == ST_SEND) && (widx == LAST);
        last_gap  = (GAP > 0) && (state == ST_GAP) && (gcnt == GAP_LAST);
        consume   = (GAP == 0) ? last_word : last_gap;
        from_pend = consume && pend_valid;
        start     = ((state == ST_IDLE) && strobe_in) || (consume && (pend_valid || strobe_in));

        if (strobe_in && (state != ST_IDLE)) begin
            if (!pend_valid)  pend_load = !consume;
            else if (consume) pend_load = 1'b1;
            else              drop      = 1'b1;
        end
        pend_clear = from_pend && !pend_load;
        shad_clear = consume && !start;

        if (from_pend) begin
            src_i = pend_i;
            src_q = pend_q;
        end
        next_word = DW'((nidx[0] ? shad_q : shad_i) >> ch_lsb(32'(nidx) >> 1, DW));

        stay_active = start
                   || ((state == ST_SEND) && !(last_word && (GAP == 0)))
                   || ((state == ST_GAP) && !last_gap);
        nxt_pend_valid = pend_load || (pend_valid && !pend_clear);
    end

    always_ff @(posedge sample_clk or negedge sample_rst_n) begin
        if (!sample_rst_n) begin
            state       <= ST_IDLE;
            widx        <= '0;
            gcnt        <= '0;
            stream_out  <= '0;
            strobe_out  <= 1'b0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
            ovf_cnt     <= '0;
        end else begin
            busy        <= stay_active || nxt_pend_valid;
            frame_start <= 1'b0;

            if (ovf_clr)                        ovf_cnt <= '0;
            else if (drop && (ovf_cnt != 8'hFF)) ovf_cnt <= ovf_cnt + 8'd1;

            if (start) begin
                state       <= ST_SEND;
                widx        <= '0;
                gcnt        <= '0;
                stream_out  <= src_i[DW-1:0];
                strobe_out  <= 1'b1;
                frame_start <= 1'b1;
            end else begin
                case (state)
                    ST_SEND: begin
                        if (last_word) begin
                            state      <= (GAP > 0) ? ST_GAP : ST_IDLE;
                            gcnt       <= '0;
                            stream_out <= '0;
                            strobe_out <= 1'b0;
                        end else begin
                            widx       <= nidx;
                            stream_out <= shad_valid ? next_word : '0;
                            strobe_out <= shad_valid;
                        end
                    end
                    ST_GAP: begin
                        if (last_gap) state <= ST_IDLE;
                        else          gcnt  <= gcnt + 4'd1;
                    end
                    default: begin
                        state      <= ST_IDLE;
                        stream_out <= '0;
                        strobe_out <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
